// File: rtl/accelerator_pkg.sv
// Shared accelerator types: identifies which requester owns the vector
// register file write port.
package accelerator_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE  = 2'd0,
      OWNER_ARITH = 2'd1,
      OWNER_VLSU  = 2'd2
   } vreg_wr_owner_t;

endpackage

// File: rtl/vreg_wr_arbiter_rr_arb2.sv
// Two-requester round-robin grant: on a tie the requester that did not win
// last is granted. Bit 0 is the arithmetic stage, bit 1 is the VLSU.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_winner,
   output logic [1:0] gnt
);

   // one-hot grant, alternating on ties
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = last_winner ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/vreg_wr_arbiter.sv
// Vector register file write-port arbiter between the arithmetic stage and the
// VLSU, with burst locking, round-robin tie-break and a stall counter.
module vreg_wr_arbiter
   import accelerator_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arith_req_i,
   input  logic              arith_last_i,
   input  logic [ADDR_W-1:0] arith_addr_i,
   input  logic [DATA_W-1:0] arith_data_i,
   input  logic [1:0]        arith_ew_i,
   output logic              arith_gnt_o,
   input  logic              lsu_req_i,
   input  logic              lsu_last_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   input  logic [1:0]        lsu_ew_i,
   output logic              lsu_gnt_o,
   output logic              vr_we_o,
   output logic [ADDR_W-1:0] vr_addr_o,
   output logic [DATA_W-1:0] vr_data_o,
   output logic [1:0]        vr_ew_o,
   output vreg_wr_owner_t    vr_src_o,
   output logic              busy_o,
   input  logic              stall_clr_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      OWN_ARITH = 2'd1,
      OWN_LSU   = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_next_s;
   vreg_wr_owner_t rr_last_r;
   logic [1:0]     rr_gnt_s;
   logic           arith_acc_s;
   logic           lsu_acc_s;
   logic [1:0]     stall_inc_s;
   logic [CNT_W:0] stall_sum_s;

   rr_arb2 u_rr_arb2 (
      .req         ({lsu_req_i, arith_req_i}),
      .last_winner (rr_last_r == OWNER_VLSU),
      .gnt         (rr_gnt_s)
   );

   // grants: round-robin only while unlocked, owner-only while locked
   always_comb begin
      arith_gnt_o = 1'b0;
      lsu_gnt_o   = 1'b0;
      case (state_r)
         IDLE: begin
            arith_gnt_o = rr_gnt_s[0];
            lsu_gnt_o   = rr_gnt_s[1];
         end
         OWN_ARITH: arith_gnt_o = 1'b1;
         OWN_LSU:   lsu_gnt_o   = 1'b1;
         default: begin
            arith_gnt_o = 1'b0;
            lsu_gnt_o   = 1'b0;
         end
      endcase
   end

   assign arith_acc_s = arith_req_i & arith_gnt_o;
   assign lsu_acc_s   = lsu_req_i & lsu_gnt_o;

   // next state: a last beat always unlocks, a non-last beat locks its source
   always_comb begin
      state_next_s = state_r;
      if (arith_acc_s) begin
         state_next_s = arith_last_i ? IDLE : OWN_ARITH;
      end else if (lsu_acc_s) begin
         state_next_s = lsu_last_i ? IDLE : OWN_LSU;
      end else begin
         state_next_s = state_r;
      end
   end

   // state, round-robin history and busy flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         rr_last_r <= OWNER_VLSU;
         busy_o    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_o  <= (state_next_s != IDLE);
         if (arith_acc_s && arith_last_i) begin
            rr_last_r <= OWNER_ARITH;
         end else if (lsu_acc_s && lsu_last_i) begin
            rr_last_r <= OWNER_VLSU;
         end
      end
   end

   // registered write port; fields hold when nothing is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         vr_we_o   <= 1'b0;
         vr_addr_o <= '0;
         vr_data_o <= '0;
         vr_ew_o   <= 2'b00;
         vr_src_o  <= OWNER_NONE;
      end else begin
         vr_we_o <= arith_acc_s | lsu_acc_s;
         if (arith_acc_s) begin
            vr_addr_o <= arith_addr_i;
            vr_data_o <= arith_data_i;
            vr_ew_o   <= arith_ew_i;
            vr_src_o  <= OWNER_ARITH;
         end else if (lsu_acc_s) begin
            vr_addr_o <= lsu_addr_i;
            vr_data_o <= lsu_data_i;
            vr_ew_o   <= lsu_ew_i;
            vr_src_o  <= OWNER_VLSU;
         end
      end
   end

   assign stall_inc_s = {1'b0, (arith_req_i & ~arith_gnt_o)}
                      + {1'b0, (lsu_req_i & ~lsu_gnt_o)};
   assign stall_sum_s = {1'b0, stall_cnt_o} + {{(CNT_W-1){1'b0}}, stall_inc_s};

   // saturating stall counter, clear wins over increment
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_o <= '0;
      end else if (stall_clr_i) begin
         stall_cnt_o <= '0;
      end else if (stall_sum_s[CNT_W]) begin
         stall_cnt_o <= '1;
      end else begin
         stall_cnt_o <= stall_sum_s[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_vreg_wr_arbiter.sv
// Directed self-checking bench for vreg_wr_arbiter: expected write beats are
// queued when a grant is predicted and compared one cycle later.
module tb_vreg_wr_arbiter;
   import accelerator_pkg::*;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 8;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [1:0]        ew;
      logic [1:0]        src;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              arith_req, arith_last, lsu_req, lsu_last;
   logic [ADDR_W-1:0] arith_addr, lsu_addr;
   logic [DATA_W-1:0] arith_data, lsu_data;
   logic [1:0]        arith_ew, lsu_ew;
   logic              arith_gnt, lsu_gnt;
   logic              vr_we;
   logic [ADDR_W-1:0] vr_addr;
   logic [DATA_W-1:0] vr_data;
   logic [1:0]        vr_ew;
   vreg_wr_owner_t    vr_src;
   logic              busy;
   logic              stall_clr;
   logic [CNT_W-1:0]  stall_cnt;

   int    checks = 0;
   int    errors = 0;
   beat_t sb_q[$];

   always #5 clk = ~clk;

   vreg_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .arith_req_i(arith_req), .arith_last_i(arith_last), .arith_addr_i(arith_addr),
      .arith_data_i(arith_data), .arith_ew_i(arith_ew), .arith_gnt_o(arith_gnt),
      .lsu_req_i(lsu_req), .lsu_last_i(lsu_last), .lsu_addr_i(lsu_addr),
      .lsu_data_i(lsu_data), .lsu_ew_i(lsu_ew), .lsu_gnt_o(lsu_gnt),
      .vr_we_o(vr_we), .vr_addr_o(vr_addr), .vr_data_o(vr_data), .vr_ew_o(vr_ew),
      .vr_src_o(vr_src), .busy_o(busy), .stall_clr_i(stall_clr), .stall_cnt_o(stall_cnt)
   );

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " vr_we"}, vr_we, 1'b0);
      chk({tag, " vr_addr"}, vr_addr, '0);
      chk({tag, " vr_data"}, vr_data, '0);
      chk({tag, " vr_ew"}, vr_ew, 2'd0);
      chk({tag, " vr_src"}, vr_src, OWNER_NONE);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " stall_cnt"}, stall_cnt, '0);
   endtask

   // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
   task automatic cycle(input string tag, input logic ea, input logic el);
      beat_t b;
      #1;
      chk({tag, " arith_gnt"}, arith_gnt, ea);
      chk({tag, " lsu_gnt"}, lsu_gnt, el);
      b = '0;
      if (ea && arith_req) begin
         b.we = 1'b1; b.addr = arith_addr; b.data = arith_data; b.ew = arith_ew; b.src = OWNER_ARITH;
      end else if (el && lsu_req) begin
         b.we = 1'b1; b.addr = lsu_addr; b.data = lsu_data; b.ew = lsu_ew; b.src = OWNER_VLSU;
      end
      sb_q.push_back(b);
      @(posedge clk);
      #1;
      b = sb_q.pop_front();
      chk({tag, " vr_we"}, vr_we, b.we);
      if (b.we) begin
         chk({tag, " vr_addr"}, vr_addr, b.addr);
         chk({tag, " vr_data"}, vr_data, b.data);
         chk({tag, " vr_ew"}, vr_ew, b.ew);
         chk({tag, " vr_src"}, vr_src, b.src);
      end
   endtask

   initial begin
      reset = 1'b1; stall_clr = 1'b0;
      arith_req = 1'b0; arith_last = 1'b0; arith_addr = '0; arith_data = '0; arith_ew = 2'd0;
      lsu_req = 1'b0; lsu_last = 1'b0; lsu_addr = '0; lsu_data = '0; lsu_ew = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      reset = 1'b0;

      // single arithmetic beat
      arith_req = 1'b1; arith_last = 1'b1; arith_addr = 5'd3; arith_data = {16{8'hA5}}; arith_ew = 2'd2;
      cycle("single", 1'b1, 1'b0);
      chk("single busy", busy, 1'b0);
      arith_req = 1'b0;

      // both requesting single beats from reset alternate, arith first
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      arith_req = 1'b1; lsu_req = 1'b1; arith_last = 1'b1; lsu_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         arith_addr = 5'(i); arith_data = {4{32'(i) ^ 32'h1111_0000}}; arith_ew = 2'(i);
         lsu_addr = 5'(16 + i); lsu_data = {4{32'(i) ^ 32'h2222_0000}}; lsu_ew = 2'(3 - i);
         cycle("alt", (i % 2) == 0, (i % 2) == 1);
         chk("alt stall_cnt", stall_cnt, 8'(i + 1));
      end

      // clear the counter
      arith_req = 1'b0; lsu_req = 1'b0; stall_clr = 1'b1;
      cycle("clr", 1'b0, 1'b0);
      chk("clr stall_cnt", stall_cnt, 8'd0);
      stall_clr = 1'b0;

      // 4-beat LSU burst locks out a continuously requesting arith stage
      arith_req = 1'b1; arith_last = 1'b1; arith_addr = 5'd7; arith_data = {8{16'hBEEF}}; arith_ew = 2'd1;
      lsu_req = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         lsu_last = (i == 4); lsu_addr = 5'(10 + i); lsu_data = {2{64'(i) * 64'h0101_0101}}; lsu_ew = 2'(i);
         cycle("lsu_burst", 1'b0, 1'b1);
         chk("lsu_burst busy", busy, (i != 4));
      end
      chk("lsu_burst stall_cnt", stall_cnt, 8'd4);
      lsu_req = 1'b0;
      cycle("after_burst", 1'b1, 1'b0);
      chk("after_burst stall_cnt", stall_cnt, 8'd4);

      // owner bubble: lock held, no write, no foreign grant
      arith_last = 1'b0; arith_addr = 5'd20;
      cycle("bubble first", 1'b1, 1'b0);
      chk("bubble busy", busy, 1'b1);
      arith_req = 1'b0; lsu_req = 1'b1; lsu_last = 1'b1; lsu_addr = 5'd30; lsu_data = {4{32'hCAFE_F00D}};
      cycle("bubble gap1", 1'b1, 1'b0);
      cycle("bubble gap2", 1'b1, 1'b0);
      arith_req = 1'b1; arith_last = 1'b1; arith_addr = 5'd21;
      cycle("bubble last", 1'b1, 1'b0);
      arith_req = 1'b0;
      cycle("bubble lsu", 1'b0, 1'b1);

      // reset in beat 2 of a 3-beat arith burst
      lsu_req = 1'b0; arith_req = 1'b1; arith_last = 1'b0; arith_addr = 5'd9;
      cycle("rst_burst b1", 1'b1, 1'b0);
      reset = 1'b1; arith_addr = 5'd10;
      #1;
      chk("rst_burst b2 arith_gnt", arith_gnt, 1'b1);
      @(posedge clk); #1;
      chk_reset("rst_burst");
      reset = 1'b0; arith_req = 1'b0; lsu_req = 1'b1; lsu_last = 1'b1; lsu_addr = 5'd5;
      cycle("rst_burst lsu", 1'b0, 1'b1);

      // saturation: arith owns a long burst while the LSU stalls every cycle
      arith_req = 1'b1; arith_last = 1'b0;
      for (int i = 0; i < 254; i++) begin
         arith_addr = 5'(i);
         cycle("sat", 1'b1, 1'b0);
      end
      chk("sat fe", stall_cnt, 8'hFE);
      cycle("sat", 1'b1, 1'b0);
      chk("sat ff", stall_cnt, 8'hFF);
      cycle("sat", 1'b1, 1'b0);
      chk("sat hold", stall_cnt, 8'hFF);
      stall_clr = 1'b1;
      cycle("sat clr", 1'b1, 1'b0);
      chk("sat clr", stall_cnt, 8'd0);
      stall_clr = 1'b0;
      cycle("sat resume", 1'b1, 1'b0);
      chk("sat resume", stall_cnt, 8'd1);
      arith_last = 1'b1;
      cycle("sat end", 1'b1, 1'b0);
      arith_req = 1'b0;
      cycle("sat lsu", 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
